axi_mem_slave: RTL and testbench
================================

Name: axi_mem_slave

Overview:
- Synthesizable AXI4 responder (slave end) backed by an internal word-addressed memory.
- Sits behind the crossbar's master ports as the default target model for system tests; pairs with the verification master driver.
- Independent write path (AW/W/B) and read path (AR/R); one outstanding burst per direction.

Parameters:
AXI_ADDR_WIDTH, 32, address width in bits
AXI_DATA_WIDTH, 64, data width in bits; power of two, >= 8
AXI_ID_WIDTH, 4, ID width in bits
AXI_USER_WIDTH, 1, user width in bits
MEM_DEPTH, 1024, memory depth in data words; power of two

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
aw_id/aw_addr/aw_len/aw_size/aw_burst/aw_atop/aw_valid  input  ID/ADDR/8/3/2/6/1  write address channel
aw_lock/aw_cache/aw_prot/aw_qos/aw_region/aw_user  input  1/4/3/4/4/USER  accepted, ignored
aw_ready  output  1
w_data/w_strb/w_last/w_valid  input  DATA/DATA/8/1/1  write data channel
w_user  input  USER  ignored
w_ready  output  1
b_id/b_resp/b_user/b_valid  output  ID/2/USER/1  write response
b_ready  input  1
ar_id/ar_addr/ar_len/ar_size/ar_burst/ar_valid  input  ID/ADDR/8/3/2/1  read address channel
ar_lock/ar_cache/ar_prot/ar_qos/ar_region/ar_user  input  1/4/3/4/4/USER  accepted, ignored
ar_ready  output  1
r_id/r_data/r_resp/r_last/r_user/r_valid  output  ID/DATA/2/1/USER/1  read data channel
r_ready  input  1

Behaviour:
- Reset: clk single clock, rst_n asynchronous active-low. All outputs 0; both FSMs to IDLE; memory contents not reset. Reset mid-burst aborts the burst silently, with no response.
- Write FSM W_IDLE -> W_DATA -> W_RESP -> W_IDLE.
  - aw_ready=1 only in W_IDLE. AW handshake latches id, addr, len, size, burst, atop; beat counter = 0; err = OKAY.
  - W_DATA: w_ready=1, starting the cycle after the AW handshake.
  - Each beat is written byte-wise per w_strb to mem[addr >> log2(DATA/8) mod-free index].
  - After each beat: addr += 2^size for INCR; addr unchanged for FIXED.
  - Burst ends on beat count = len+1, not on w_last.
  - W_RESP: b_valid=1 from the cycle after the last beat; b_id = latched id; b_user=0. Held until b_ready, then W_IDLE.
- Read FSM R_IDLE -> R_DATA -> R_IDLE.
  - ar_ready=1 only in R_IDLE.
  - R_DATA: r_valid=1 from the cycle after the AR handshake.
  - r_data = mem[current word index], combinational from the address register.
  - r_last=1 on beat len; r_id = latched id; r_user=0.
  - Beat advances on r_valid & r_ready. Back-to-back beats at 1/cycle while r_ready=1. Outputs are stable while stalled.
- Error rules:
  - size != log2(DATA/8), burst=WRAP or reserved, or atop != 0: SLVERR for the whole burst. Beats are still absorbed or returned; memory is not written; read data is 0.
  - Beat word index >= MEM_DEPTH: DECERR for that beat. The beat is not written; read data is 0.
  - w_last value != (beat==len): SLVERR.
  - b_resp = highest-priority error seen in the burst (DECERR > SLVERR > OKAY).
  - r_resp is per beat.
- Unaligned start addr: aligned down to the word; strobes are honoured as given.
- Concurrency: read and write paths are fully independent. A write in cycle N is visible to a read beat presented in cycle N+1 or later. No 4KB-boundary check.

Test Plan:
- Single write then read: AW addr=0x40, len=0, size=3, INCR, w_data=0x1122334455667788, strb=0xFF -> B OKAY 2 cycles after AW; AR addr=0x40 -> R data 0x1122334455667788, r_last=1, OKAY.
- INCR burst with stall: write len=3 at 0x100 with data 0..3, then read len=3 with r_ready toggling 1,0,1,0 -> 4 beats 0,1,2,3 in order; data held during stalls; r_last only on beat 3.
- Strobe/FIXED: FIXED len=1 at 0x8, beat0=all-F strb 0xFF, beat1=0 strb 0x0F -> read returns 0xFFFFFFFF00000000.
- Errors: AR addr = MEM_DEPTH*8 -> r_resp=DECERR, data 0; AW burst=WRAP len=1 -> 2 beats absorbed, b_resp=SLVERR, memory unchanged; w_last early on beat 0 of len=1 -> SLVERR.
- ID/concurrency: simultaneous AW id=5 and AR id=9 in the same cycle -> both accepted in that cycle; b_id=5, r_id=9.
- Reset mid-burst: assert rst_n=0 during beat 2 of a len=7 read -> r_valid=0 immediately; ar_ready=1 after release; next read completes normally.

Source files
------------

// File: rtl/axi_mem_slave_if.sv
// AXI4 bundle between a verification master and the memory responder.
// Five channels, each a valid/ready handshake.
interface axi_mem_slave_if #(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 64,
    parameter int AXI_ID_WIDTH   = 4,
    parameter int AXI_USER_WIDTH = 1
);
    localparam int STRB_WIDTH = AXI_DATA_WIDTH / 8;

    logic [AXI_ID_WIDTH-1:0]   aw_id;
    logic [AXI_ADDR_WIDTH-1:0] aw_addr;
    logic [7:0]                aw_len;
    logic [2:0]                aw_size;
    logic [1:0]                aw_burst;
    logic [5:0]                aw_atop;
    logic                      aw_lock;
    logic [3:0]                aw_cache;
    logic [2:0]                aw_prot;
    logic [3:0]                aw_qos;
    logic [3:0]                aw_region;
    logic [AXI_USER_WIDTH-1:0] aw_user;
    logic                      aw_valid;
    logic                      aw_ready;

    logic [AXI_DATA_WIDTH-1:0] w_data;
    logic [STRB_WIDTH-1:0]     w_strb;
    logic                      w_last;
    logic [AXI_USER_WIDTH-1:0] w_user;
    logic                      w_valid;
    logic                      w_ready;

    logic [AXI_ID_WIDTH-1:0]   b_id;
    logic [1:0]                b_resp;
    logic [AXI_USER_WIDTH-1:0] b_user;
    logic                      b_valid;
    logic                      b_ready;

    logic [AXI_ID_WIDTH-1:0]   ar_id;
    logic [AXI_ADDR_WIDTH-1:0] ar_addr;
    logic [7:0]                ar_len;
    logic [2:0]                ar_size;
    logic [1:0]                ar_burst;
    logic                      ar_lock;
    logic [3:0]                ar_cache;
    logic [2:0]                ar_prot;
    logic [3:0]                ar_qos;
    logic [3:0]                ar_region;
    logic [AXI_USER_WIDTH-1:0] ar_user;
    logic                      ar_valid;
    logic                      ar_ready;

    logic [AXI_ID_WIDTH-1:0]   r_id;
    logic [AXI_DATA_WIDTH-1:0] r_data;
    logic [1:0]                r_resp;
    logic                      r_last;
    logic [AXI_USER_WIDTH-1:0] r_user;
    logic                      r_valid;
    logic                      r_ready;

    modport master (
        output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_atop,
        output aw_lock, aw_cache, aw_prot, aw_qos, aw_region, aw_user,
        output aw_valid,
        input  aw_ready,
        output w_data, w_strb, w_last, w_user, w_valid,
        input  w_ready,
        input  b_id, b_resp, b_user, b_valid,
        output b_ready,
        output ar_id, ar_addr, ar_len, ar_size, ar_burst,
        output ar_lock, ar_cache, ar_prot, ar_qos, ar_region, ar_user,
        output ar_valid,
        input  ar_ready,
        input  r_id, r_data, r_resp, r_last, r_user, r_valid,
        output r_ready
    );

    modport slave (
        input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_atop,
        input  aw_lock, aw_cache, aw_prot, aw_qos, aw_region, aw_user,
        input  aw_valid,
        output aw_ready,
        input  w_data, w_strb, w_last, w_user, w_valid,
        output w_ready,
        output b_id, b_resp, b_user, b_valid,
        input  b_ready,
        input  ar_id, ar_addr, ar_len, ar_size, ar_burst,
        input  ar_lock, ar_cache, ar_prot, ar_qos, ar_region, ar_user,
        input  ar_valid,
        output ar_ready,
        output r_id, r_data, r_resp, r_last, r_user, r_valid,
        input  r_ready
    );
endinterface

// File: rtl/axi_mem_slave.sv
// AXI4 memory responder: independent AW/W/B and AR/R engines over a
// byte-strobed word memory, one burst in flight per direction.
module axi_mem_slave #(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 64,
    parameter int AXI_ID_WIDTH   = 4,
    parameter int AXI_USER_WIDTH = 1,
    parameter int MEM_DEPTH      = 1024
) (
    input logic            clk,
    input logic            rst_n,
    axi_mem_slave_if.slave bus
);
    localparam int AW    = AXI_ADDR_WIDTH;
    localparam int DW    = AXI_DATA_WIDTH;
    localparam int BYTES = DW / 8;
    localparam int OFF   = $clog2(BYTES);
    localparam int IW    = AW - OFF;
    localparam int MW    = $clog2(MEM_DEPTH);

    localparam logic [IW-1:0] LIMIT   = IW'(MEM_DEPTH);
    localparam logic [2:0]    SIZE_OK = 3'(OFF);
    localparam logic [1:0]    OKAY    = 2'b00;
    localparam logic [1:0]    SLVERR  = 2'b10;
    localparam logic [1:0]    DECERR  = 2'b11;
    localparam logic [1:0]    FIXED   = 2'b00;
    localparam logic [1:0]    INCR    = 2'b01;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    function automatic logic bad_cfg(
        input logic [2:0] size,
        input logic [1:0] burst,
        input logic [5:0] atop
    );
        return (size != SIZE_OK)
            || (burst != FIXED && burst != INCR)
            || (atop != 6'd0);
    endfunction

    logic [DW-1:0] mem [MEM_DEPTH];

    // ---------------- write path ----------------
    w_state_t              w_state;
    w_state_t              w_nx;
    logic                  aw_rdy;
    logic                  w_rdy;
    logic                  b_vld;
    logic [AXI_ID_WIDTH-1:0] w_id;
    logic [AW-1:0]         w_addr;
    logic [7:0]            w_len;
    logic [2:0]            w_size;
    logic                  w_fixed;
    logic                  w_cfg_err;
    logic [7:0]            w_beat;
    logic [1:0]            w_err;
    logic                  aw_fire;
    logic                  w_fire;
    logic                  w_end;
    logic [IW-1:0]         w_idx;
    logic                  w_oob;
    logic [1:0]            w_bresp;
    logic [AW-1:0]         w_step;
    logic                  mem_we;

    assign aw_fire = bus.aw_ready & bus.aw_valid;
    assign w_fire  = w_rdy & bus.w_valid;
    assign w_end   = (w_beat == w_len);
    assign w_idx   = w_addr[AW-1:OFF];
    assign w_oob   = (w_idx >= LIMIT);
    assign w_step  = w_fixed ? '0 : (AW'(1) << w_size);
    assign mem_we  = w_fire & ~w_cfg_err & ~w_oob;

    // Burst length comes from aw_len; w_last only feeds the error check.
    always_comb begin
        w_bresp = OKAY;
        if (w_oob)
            w_bresp = DECERR;
        else if (w_cfg_err || (bus.w_last != w_end))
            w_bresp = SLVERR;
    end

    always_comb begin
        w_nx   = w_state;
        aw_rdy = 1'b0;
        w_rdy  = 1'b0;
        b_vld  = 1'b0;
        unique case (w_state)
            W_IDLE: begin
                aw_rdy = 1'b1;
                if (bus.aw_valid) w_nx = W_DATA;
            end
            W_DATA: begin
                w_rdy = 1'b1;
                if (bus.w_valid && w_end) w_nx = W_RESP;
            end
            W_RESP: begin
                b_vld = 1'b1;
                if (bus.b_ready) w_nx = W_IDLE;
            end
            default: w_nx = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) w_state <= W_IDLE;
        else        w_state <= w_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_id      <= '0;
            w_addr    <= '0;
            w_len     <= '0;
            w_size    <= '0;
            w_fixed   <= 1'b0;
            w_cfg_err <= 1'b0;
            w_beat    <= '0;
            w_err     <= OKAY;
        end else if (aw_fire) begin
            w_id      <= bus.aw_id;
            w_addr    <= bus.aw_addr;
            w_len     <= bus.aw_len;
            w_size    <= bus.aw_size;
            w_fixed   <= (bus.aw_burst == FIXED);
            w_cfg_err <= bad_cfg(bus.aw_size, bus.aw_burst,
                                 bus.aw_atop);
            w_beat    <= '0;
            w_err     <= OKAY;
        end else if (w_fire) begin
            w_beat <= w_beat + 8'd1;
            w_addr <= w_addr + w_step;
            if (w_bresp > w_err) w_err <= w_bresp;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < BYTES; i++) begin
                if (bus.w_strb[i])
                    mem[w_idx[MW-1:0]][8*i +: 8] <= bus.w_data[8*i +: 8];
            end
        end
    end

    assign bus.aw_ready = aw_rdy & rst_n;
    assign bus.w_ready  = w_rdy;
    assign bus.b_valid  = b_vld;
    assign bus.b_id     = b_vld ? w_id : '0;
    assign bus.b_resp   = b_vld ? w_err : OKAY;
    assign bus.b_user   = '0;

    // ---------------- read path ----------------
    r_state_t              r_state;
    r_state_t              r_nx;
    logic                  ar_rdy;
    logic                  r_vld;
    logic [AXI_ID_WIDTH-1:0] r_id;
    logic [AW-1:0]         r_addr;
    logic [7:0]            r_len;
    logic [2:0]            r_size;
    logic                  r_fixed;
    logic                  r_cfg_err;
    logic [7:0]            r_beat;
    logic                  ar_fire;
    logic                  r_fire;
    logic                  r_end;
    logic [IW-1:0]         r_idx;
    logic                  r_oob;
    logic [1:0]            r_bresp;
    logic [AW-1:0]         r_step;

    assign ar_fire = bus.ar_ready & bus.ar_valid;
    assign r_fire  = r_vld & bus.r_ready;
    assign r_end   = (r_beat == r_len);
    assign r_idx   = r_addr[AW-1:OFF];
    assign r_oob   = (r_idx >= LIMIT);
    assign r_step  = r_fixed ? '0 : (AW'(1) << r_size);

    always_comb begin
        r_bresp = OKAY;
        if (r_oob)          r_bresp = DECERR;
        else if (r_cfg_err) r_bresp = SLVERR;
    end

    always_comb begin
        r_nx   = r_state;
        ar_rdy = 1'b0;
        r_vld  = 1'b0;
        unique case (r_state)
            R_IDLE: begin
                ar_rdy = 1'b1;
                if (bus.ar_valid) r_nx = R_DATA;
            end
            R_DATA: begin
                r_vld = 1'b1;
                if (bus.r_ready && r_end) r_nx = R_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= R_IDLE;
        else        r_state <= r_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_id      <= '0;
            r_addr    <= '0;
            r_len     <= '0;
            r_size    <= '0;
            r_fixed   <= 1'b0;
            r_cfg_err <= 1'b0;
            r_beat    <= '0;
        end else if (ar_fire) begin
            r_id      <= bus.ar_id;
            r_addr    <= bus.ar_addr;
            r_len     <= bus.ar_len;
            r_size    <= bus.ar_size;
            r_fixed   <= (bus.ar_burst == FIXED);
            r_cfg_err <= bad_cfg(bus.ar_size, bus.ar_burst, 6'd0);
            r_beat    <= '0;
        end else if (r_fire) begin
            r_beat <= r_beat + 8'd1;
            r_addr <= r_addr + r_step;
        end
    end

    // Data is a live view of the addressed word, so fresh writes show at once.
    assign bus.ar_ready = ar_rdy & rst_n;
    assign bus.r_valid  = r_vld;
    assign bus.r_id     = r_vld ? r_id : '0;
    assign bus.r_resp   = r_vld ? r_bresp : OKAY;
    assign bus.r_last   = r_vld & r_end;
    assign bus.r_user   = '0;
    assign bus.r_data   = (r_vld && r_bresp == OKAY)
                        ? mem[r_idx[MW-1:0]] : '0;

    logic unused;
    assign unused = ^{bus.aw_lock, bus.aw_cache, bus.aw_prot,
                      bus.aw_qos, bus.aw_region, bus.aw_user,
                      bus.w_user, bus.ar_lock, bus.ar_cache,
                      bus.ar_prot, bus.ar_qos, bus.ar_region,
                      bus.ar_user, w_addr[OFF-1:0],
                      r_addr[OFF-1:0]};
endmodule

// File: tb/tb_axi_mem_slave.sv
// Directed bench for axi_mem_slave: a transaction-level memory model
// predicts every B and R beat, checked each cycle by one monitor.
module tb_axi_mem_slave;
    localparam int DEPTH = 1024;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    axi_mem_slave_if #(
        .AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(64),
        .AXI_ID_WIDTH(4), .AXI_USER_WIDTH(1)
    ) bus ();

    axi_mem_slave #(
        .AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(64),
        .AXI_ID_WIDTH(4), .AXI_USER_WIDTH(1),
        .MEM_DEPTH(DEPTH)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct packed {
        logic [63:0] data;
        logic [1:0]  resp;
        logic        last;
        logic [3:0]  id;
    } rbeat_t;

    typedef struct packed {
        logic [3:0] id;
        logic [1:0] resp;
    } bexp_t;

    int checks = 0;
    int fails  = 0;

    bit [63:0]   mmem [int unsigned];
    rbeat_t      rexp [$];
    bexp_t       bexp [$];

    logic [63:0] wdata [16];
    logic [7:0]  wstrb [16];

    logic [63:0] cap_data [16];
    logic [1:0]  cap_resp [16];
    logic        cap_last [16];
    logic [3:0]  cap_id;
    logic [1:0]  cap_bresp;
    logic [3:0]  cap_bid;
    int          aw_cyc, ar_cyc, b_cyc;

    function automatic void chk(input string name,
                                input logic [63:0] act,
                                input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endfunction

    function automatic bit cfg_bad(input logic [2:0] size,
                                   input logic [1:0] burst,
                                   input logic [5:0] atop);
        return (size != 3'd3) || (burst > 2'd1) || (atop != 6'd0);
    endfunction

    // Model of a read burst: what each beat must carry.
    function automatic void exp_read(input logic [3:0] id,
                                     input logic [31:0] addr,
                                     input int len,
                                     input logic [2:0] size,
                                     input logic [1:0] burst);
        logic [31:0] a;
        int unsigned idx;
        rbeat_t e;
        bit bad;
        a = addr;
        bad = cfg_bad(size, burst, 6'd0);
        for (int i = 0; i <= len; i++) begin
            idx = a >> 3;
            e.id = id;
            e.last = (i == len);
            if (idx >= DEPTH) begin
                e.resp = 2'b11; e.data = '0;
            end else if (bad) begin
                e.resp = 2'b10; e.data = '0;
            end else begin
                e.resp = 2'b00;
                e.data = mmem.exists(idx) ? mmem[idx] : 64'd0;
            end
            rexp.push_back(e);
            if (burst == 2'd1) a = a + (32'd1 << size);
        end
    endfunction

    task automatic do_write(input logic [3:0] id,
                            input logic [31:0] addr,
                            input int len,
                            input logic [2:0] size,
                            input logic [1:0] burst,
                            input logic [5:0] atop,
                            input int bad_last);
        logic [31:0] a;
        logic [1:0] worst, r;
        int unsigned idx;
        bit bad;
        bit [63:0] w;
        bexp_t be;
        int n;
        a = addr;
        worst = 2'b00;
        bad = cfg_bad(size, burst, atop);
        for (int i = 0; i <= len; i++) begin
            idx = a >> 3;
            if (idx >= DEPTH) r = 2'b11;
            else if (bad || i == bad_last) r = 2'b10;
            else r = 2'b00;
            if (r > worst) worst = r;
            if (!bad && idx < DEPTH) begin
                w = mmem.exists(idx) ? mmem[idx] : 64'd0;
                for (int b = 0; b < 8; b++)
                    if (wstrb[i][b]) w[8*b +: 8] = wdata[i][8*b +: 8];
                mmem[idx] = w;
            end
            if (burst == 2'd1) a = a + (32'd1 << size);
        end
        be.id = id;
        be.resp = worst;
        bexp.push_back(be);

        @(posedge clk); #1;
        bus.aw_id = id; bus.aw_addr = addr; bus.aw_len = 8'(len);
        bus.aw_size = size; bus.aw_burst = burst; bus.aw_atop = atop;
        bus.aw_valid = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end
        while (!bus.aw_ready && n < 50);
        if (!bus.aw_ready) chk("aw_timeout", 64'd0, 64'd1);
        aw_cyc = cyc;
        @(posedge clk); #1;
        bus.aw_valid = 1'b0;
        for (int i = 0; i <= len; i++) begin
            bus.w_data = wdata[i];
            bus.w_strb = wstrb[i];
            bus.w_last = (i == len) || (i == bad_last);
            bus.w_valid = 1'b1;
            n = 0;
            do begin @(negedge clk); n++; end
            while (!bus.w_ready && n < 50);
            if (!bus.w_ready) chk("w_timeout", 64'd0, 64'd1);
            @(posedge clk); #1;
        end
        bus.w_valid = 1'b0;
        bus.w_last = 1'b0;
        n = 0;
        while (!bus.b_valid && n < 20) begin
            @(negedge clk); n++;
        end
        if (n == 0) @(negedge clk);
        if (!bus.b_valid) chk("b_timeout", 64'd0, 64'd1);
        b_cyc = cyc;
        cap_bresp = bus.b_resp;
        cap_bid = bus.b_id;
        @(posedge clk); #1;
    endtask

    task automatic do_read(input logic [3:0] id,
                           input logic [31:0] addr,
                           input int len,
                           input logic [2:0] size,
                           input logic [1:0] burst,
                           input bit toggle);
        int n, got, k;
        exp_read(id, addr, len, size, burst);
        @(posedge clk); #1;
        bus.ar_id = id; bus.ar_addr = addr; bus.ar_len = 8'(len);
        bus.ar_size = size; bus.ar_burst = burst;
        bus.ar_valid = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end
        while (!bus.ar_ready && n < 50);
        if (!bus.ar_ready) chk("ar_timeout", 64'd0, 64'd1);
        ar_cyc = cyc;
        @(posedge clk); #1;
        bus.ar_valid = 1'b0;
        got = 0; k = 0; n = 0;
        while (got <= len && n < 200) begin
            bus.r_ready = toggle ? (k % 2 == 0) : 1'b1;
            k++;
            @(negedge clk);
            if (bus.r_valid && bus.r_ready) begin
                cap_data[got] = bus.r_data;
                cap_resp[got] = bus.r_resp;
                cap_last[got] = bus.r_last;
                cap_id = bus.r_id;
                got++;
            end
            @(posedge clk); #1;
            n++;
        end
        bus.r_ready = 1'b1;
        chk("r_beat_count", 64'(got), 64'(len + 1));
    endtask

    // Monitor: every presented R/B beat must match the model's head.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (bus.r_valid) begin
                if (rexp.size() == 0) begin
                    chk("r_unexpected", 64'd1, 64'd0);
                end else begin
                    chk("r_data", bus.r_data, rexp[0].data);
                    chk("r_resp", 64'(bus.r_resp), 64'(rexp[0].resp));
                    chk("r_last", 64'(bus.r_last), 64'(rexp[0].last));
                    chk("r_id", 64'(bus.r_id), 64'(rexp[0].id));
                    if (bus.r_ready) void'(rexp.pop_front());
                end
            end
            if (bus.b_valid) begin
                if (bexp.size() == 0) begin
                    chk("b_unexpected", 64'd1, 64'd0);
                end else begin
                    chk("b_resp", 64'(bus.b_resp), 64'(bexp[0].resp));
                    chk("b_id", 64'(bus.b_id), 64'(bexp[0].id));
                    if (bus.b_ready) void'(bexp.pop_front());
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1);
    end

    initial begin
        int n, got;
        rst_n = 1'b0;
        bus.aw_id = '0; bus.aw_addr = '0; bus.aw_len = '0;
        bus.aw_size = '0; bus.aw_burst = '0; bus.aw_atop = '0;
        bus.aw_lock = '0; bus.aw_cache = '0; bus.aw_prot = '0;
        bus.aw_qos = '0; bus.aw_region = '0; bus.aw_user = '0;
        bus.aw_valid = 1'b0;
        bus.w_data = '0; bus.w_strb = '0; bus.w_last = 1'b0;
        bus.w_user = '0; bus.w_valid = 1'b0;
        bus.b_ready = 1'b1;
        bus.ar_id = '0; bus.ar_addr = '0; bus.ar_len = '0;
        bus.ar_size = '0; bus.ar_burst = '0;
        bus.ar_lock = '0; bus.ar_cache = '0; bus.ar_prot = '0;
        bus.ar_qos = '0; bus.ar_region = '0; bus.ar_user = '0;
        bus.ar_valid = 1'b0;
        bus.r_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_aw_ready", 64'(bus.aw_ready), 64'd0);
        chk("rst_ar_ready", 64'(bus.ar_ready), 64'd0);
        chk("rst_w_ready", 64'(bus.w_ready), 64'd0);
        chk("rst_b_valid", 64'(bus.b_valid), 64'd0);
        chk("rst_r_valid", 64'(bus.r_valid), 64'd0);
        chk("rst_r_data", bus.r_data, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst_aw_ready", 64'(bus.aw_ready), 64'd1);
        chk("post_rst_ar_ready", 64'(bus.ar_ready), 64'd1);

        // single write then read
        wdata[0] = 64'h1122334455667788; wstrb[0] = 8'hFF;
        do_write(4'd1, 32'h40, 0, 3'd3, 2'd1, 6'd0, -1);
        chk("t1_b_latency", 64'(b_cyc - aw_cyc), 64'd2);
        chk("t1_b_resp", 64'(cap_bresp), 64'd0);
        do_read(4'd1, 32'h40, 0, 3'd3, 2'd1, 1'b0);
        chk("t1_r_data", cap_data[0], 64'h1122334455667788);
        chk("t1_r_last", 64'(cap_last[0]), 64'd1);
        chk("t1_r_resp", 64'(cap_resp[0]), 64'd0);

        // INCR burst, read back with r_ready stalls
        for (int i = 0; i < 4; i++) begin
            wdata[i] = 64'(i); wstrb[i] = 8'hFF;
        end
        do_write(4'd2, 32'h100, 3, 3'd3, 2'd1, 6'd0, -1);
        do_read(4'd2, 32'h100, 3, 3'd3, 2'd1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            chk("t2_data", cap_data[i], 64'(i));
            chk("t2_last", 64'(cap_last[i]), 64'(i == 3));
        end

        // FIXED burst with partial strobe on the second beat
        wdata[0] = 64'hFFFF_FFFF_FFFF_FFFF; wstrb[0] = 8'hFF;
        wdata[1] = 64'h0;                   wstrb[1] = 8'h0F;
        do_write(4'd3, 32'h8, 1, 3'd3, 2'd0, 6'd0, -1);
        do_read(4'd3, 32'h8, 0, 3'd3, 2'd1, 1'b0);
        chk("t3_fixed_data", cap_data[0], 64'hFFFF_FFFF_0000_0000);

        // DECERR read just past the end of memory
        do_read(4'd4, 32'(DEPTH * 8), 0, 3'd3, 2'd1, 1'b0);
        chk("t4_dec_resp", 64'(cap_resp[0]), 64'd3);
        chk("t4_dec_data", cap_data[0], 64'd0);

        // WRAP write is absorbed without touching memory
        wdata[0] = 64'hAAAA_AAAA_AAAA_AAAA; wstrb[0] = 8'hFF;
        do_write(4'd5, 32'h300, 0, 3'd3, 2'd1, 6'd0, -1);
        wdata[0] = 64'h5555_5555_5555_5555; wstrb[0] = 8'hFF;
        wdata[1] = 64'h5555_5555_5555_5555; wstrb[1] = 8'hFF;
        do_write(4'd5, 32'h300, 1, 3'd3, 2'd2, 6'd0, -1);
        chk("t5_wrap_bresp", 64'(cap_bresp), 64'd2);
        do_read(4'd5, 32'h300, 0, 3'd3, 2'd1, 1'b0);
        chk("t5_mem_kept", cap_data[0], 64'hAAAA_AAAA_AAAA_AAAA);

        // early w_last
        wdata[0] = 64'h1; wdata[1] = 64'h2;
        wstrb[0] = 8'hFF; wstrb[1] = 8'hFF;
        do_write(4'd6, 32'h310, 1, 3'd3, 2'd1, 6'd0, 0);
        chk("t6_early_last", 64'(cap_bresp), 64'd2);

        // simultaneous AW and AR
        wdata[0] = 64'hDEAD_BEEF; wstrb[0] = 8'hFF;
        fork
            do_write(4'd5, 32'h400, 0, 3'd3, 2'd1, 6'd0, -1);
            do_read(4'd9, 32'h100, 0, 3'd3, 2'd1, 1'b0);
        join
        chk("t7_same_cycle", 64'(ar_cyc), 64'(aw_cyc));
        chk("t7_b_id", 64'(cap_bid), 64'd5);
        chk("t7_r_id", 64'(cap_id), 64'd9);

        // reset during beat 2 of a len=7 read
        for (int i = 0; i < 8; i++) begin
            wdata[i] = 64'h100 + 64'(i); wstrb[i] = 8'hFF;
        end
        do_write(4'd7, 32'h200, 7, 3'd3, 2'd1, 6'd0, -1);
        exp_read(4'd7, 32'h200, 7, 3'd3, 2'd1);
        @(posedge clk); #1;
        bus.ar_id = 4'd7; bus.ar_addr = 32'h200; bus.ar_len = 8'd7;
        bus.ar_size = 3'd3; bus.ar_burst = 2'd1;
        bus.ar_valid = 1'b1; bus.r_ready = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end
        while (!bus.ar_ready && n < 50);
        @(posedge clk); #1;
        bus.ar_valid = 1'b0;
        got = 0; n = 0;
        while (n < 50) begin
            @(negedge clk);
            n++;
            if (bus.r_valid) begin
                if (got == 2) break;
                got++;
            end
        end
        chk("t8_reached_beat2", 64'(got), 64'd2);
        #1 rst_n = 1'b0;
        #1;
        chk("t8_r_valid_drop", 64'(bus.r_valid), 64'd0);
        rexp.delete();
        bexp.delete();
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        chk("t8_ar_ready", 64'(bus.ar_ready), 64'd1);
        do_read(4'd8, 32'h200, 1, 3'd3, 2'd1, 1'b0);
        chk("t8_after_d0", cap_data[0], 64'h100);
        chk("t8_after_d1", cap_data[1], 64'h101);
        chk("t8_after_last", 64'(cap_last[1]), 64'd1);

        repeat (3) @(posedge clk);
        #1;
        chk("rexp_drained", 64'(rexp.size()), 64'd0);
        chk("bexp_drained", 64'(bexp.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end
endmodule
